// File: rtl/seg7_scan_driver.sv
// Scans a 32-bit display word as 8 hex digits onto a common-anode 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN suppresses digits above the most significant nonzero nibble.
module seg7_scan_driver #(
    parameter int CLK_DIV = 4,
    parameter int DIV_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] disp_data,
    input  logic [7:0]  dp_mask,
    input  logic        blank,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      shadow_q, shadow_d;
    logic             first_q, first_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             tick;
    logic             load;
`ifdef LEADING_ZERO_BLANK_EN
    logic [2:0]       msd_q, msd_d;
`endif

    function automatic logic [6:0] hexdecode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    function automatic logic [2:0] msd_of(input logic [31:0] v);
        logic [2:0] m;
        m = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (v[4*k +: 4] != 4'h0) m = 3'(k);
        end
        return m;
    endfunction
`endif

    assign tick = (div_q == DIV_LAST);
    // Snapshot only at frame wrap so a scan never mixes words; the first tick after reset also loads.
    assign load = tick && ((idx_q == 3'd7) || first_q);

    always_comb begin
        div_d    = tick ? '0 : div_q + DIV_W'(1);
        idx_d    = tick ? idx_q + 3'd1 : idx_q;
        shadow_d = load ? disp_data : shadow_q;
        first_d  = first_q && !tick;
        an_d     = blank ? 8'hFF : ~(8'b1 << idx_q);
        seg_d    = hexdecode(shadow_q[{idx_q, 2'b00} +: 4]);
        dp_d     = blank | ~dp_mask[idx_q];
`ifdef LEADING_ZERO_BLANK_EN
        msd_d    = load ? msd_of(disp_data) : msd_q;
        if (idx_q > msd_q) begin
            an_d  = 8'hFF;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= '0;
            idx_q    <= 3'd0;
            shadow_q <= 32'h0;
            first_q  <= 1'b1;
            an_q     <= 8'hFF;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
            msd_q    <= 3'd0;
`endif
        end else begin
            div_q    <= div_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            first_q  <= first_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
`ifdef LEADING_ZERO_BLANK_EN
            msd_q    <= msd_d;
`endif
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: two instances (CLK_DIV=4 and CLK_DIV=1) checked
// every cycle against a slot-arithmetic reference model.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] disp_data;
    logic [7:0]  dp_mask;
    logic        blank;
    logic [7:0]  an4, an1;
    logic [6:0]  seg4, seg1;
    logic        dp4, dp1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] q4[$];
    logic [15:0] q1[$];

    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_driver #(.CLK_DIV(4), .DIV_W(16)) u_dut4 (
        .clk(clk), .reset(reset), .disp_data(disp_data), .dp_mask(dp_mask), .blank(blank),
        .an(an4), .seg(seg4), .dp(dp4)
    );

    seg7_scan_driver #(.CLK_DIV(1), .DIV_W(16)) u_dut1 (
        .clk(clk), .reset(reset), .disp_data(disp_data), .dp_mask(dp_mask), .blank(blank),
        .an(an1), .seg(seg1), .dp(dp1)
    );

    always #5 clk = ~clk;

    // Model: state after n non-reset edges is slot n/cd; the word is captured on the 1st tick
    // and on every 8th tick; outputs at an edge reflect the state before that edge.
    task automatic model_step(input int cd, inout int n, inout logic [31:0] sh, inout int msd,
                              output logic [15:0] exp_o);
        int idx;
        int k;
        logic [7:0] a;
        logic [6:0] s;
        logic d;
        if (reset) begin
            n = 0; sh = 32'h0; msd = 0;
            exp_o = {8'hFF, 7'h7F, 1'b1};
        end else begin
            idx = (n / cd) % 8;
            a = blank ? 8'hFF : ~(8'(1) << idx);
            s = HEX[(sh >> (4 * idx)) & 32'hF];
            d = blank ? 1'b1 : ~dp_mask[idx];
`ifdef LEADING_ZERO_BLANK_EN
            if (idx > msd) begin a = 8'hFF; s = 7'h7F; d = 1'b1; end
`endif
            exp_o = {a, s, d};
            n++;
            if (n % cd == 0) begin
                k = n / cd;
                if (k == 1 || k % 8 == 0) begin
                    sh = disp_data;
                    msd = 0;
                    for (int j = 7; j >= 0; j--) begin
                        if (((sh >> (4 * j)) & 32'hF) != 0) begin msd = j; break; end
                    end
                end
            end
        end
    endtask

    initial begin : model4
        int n = 0; logic [31:0] sh = 0; int msd = 0; logic [15:0] e;
        forever begin
            @(posedge clk);
            model_step(4, n, sh, msd, e);
            q4.push_back(e);
        end
    end

    initial begin : model1
        int n = 0; logic [31:0] sh = 0; int msd = 0; logic [15:0] e;
        forever begin
            @(posedge clk);
            model_step(1, n, sh, msd, e);
            q1.push_back(e);
        end
    end

    initial begin : monitor
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (q4.size() > 0) begin
                e = q4.pop_front();
                n_checks++;
                if ({an4, seg4, dp4} !== e) begin
                    n_fail++;
                    $display("FAIL div4_out t=%0t an/seg/dp got %h/%h/%b want %h/%h/%b",
                             $time, an4, seg4, dp4, e[15:8], e[7:1], e[0]);
                end
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                n_checks++;
                if ({an1, seg1, dp1} !== e) begin
                    n_fail++;
                    $display("FAIL div1_out t=%0t an/seg/dp got %h/%h/%b want %h/%h/%b",
                             $time, an1, seg1, dp1, e[15:8], e[7:1], e[0]);
                end
            end
        end
    end

    task automatic run(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin : driver
        reset = 1'b1; disp_data = 32'h0000_0007; dp_mask = 8'h00; blank = 1'b0;
        run(3);
        reset = 1'b0;
        run(72);
        disp_data = 32'h1234_ABCD;
        run(45);
        disp_data = 32'hFFFF_FFFF;
        run(50);
        dp_mask = 8'h10;
        run(9);
        blank = 1'b1;
        run(4);
        blank = 1'b0;
        run(40);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) disp_data = $urandom;
            if ($urandom_range(0, 5) == 0) dp_mask = 8'($urandom);
            blank = ($urandom_range(0, 7) == 0);
            run(1);
        end
        blank = 1'b0;
        run(13);
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        disp_data = 32'h0000_0054;
        run(80);
        disp_data = 32'h0000_0000;
        run(80);
        disp_data = 32'h0A00_0000;
        run(40);
        run(2);
        if (q4.size() > 1 || q1.size() > 1) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain pending got %0d/%0d want <=1", q4.size(), q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
